// File: rtl/alt_ddr2_agx2_arb_pkg.sv
// Shared types and helpers for the DDR2 local-port arbiter.
package alt_ddr2_agx2_arb_pkg;

    // Port index is sized for the largest supported port count (4).
    localparam int MAX_PORTS  = 4;
    localparam int TAG_PORT_W = 2;
    // Burst size field in a tag; wide enough for any supported SIZE_W.
    localparam int TAG_SIZE_W = 8;

    // One outstanding read: which port issued it and how many beats it returns.
    typedef struct packed {
        logic [TAG_PORT_W-1:0] port;
        logic [TAG_SIZE_W-1:0] size;
    } tag_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } arb_state_t;

    // Round-robin search: first requester after ptr, wrapping at num_ports.
    // Returns {found, index}.
    function automatic logic [TAG_PORT_W:0] rr_pick(
        input logic [MAX_PORTS-1:0]  req,
        input logic [TAG_PORT_W-1:0] ptr,
        input int                    num_ports
    );
        logic                  found;
        logic [TAG_PORT_W-1:0] idx;
        int                    cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= num_ports) begin
                cand = cand - num_ports;
            end else begin
                cand = cand;
            end
            if (!found && (k <= num_ports) && req[cand[TAG_PORT_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[TAG_PORT_W-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // A burst size of zero behaves exactly like a single beat.
    function automatic logic [TAG_SIZE_W-1:0] eff_size(input logic [TAG_SIZE_W-1:0] s);
        return (s == '0) ? TAG_SIZE_W'(1) : s;
    endfunction

endpackage

// File: rtl/alt_ddr2_agx2_tag_fifo.sv
// Synchronous FIFO of read tags; push and pop may occur in the same cycle.
module alt_ddr2_agx2_tag_fifo
    import alt_ddr2_agx2_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    tag_t            mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Flags and qualified push/pop strobes.
    always_comb begin
        full      = (count_r == (AW+1)'(DEPTH));
        empty     = (count_r == '0);
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        head      = mem_r[rd_ptr_r];
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_tag;
        end
    end

endmodule

// File: rtl/alt_ddr2_agx2_local_arbiter.sv
// Round-robin arbiter sharing one DDR2 local command port among several
// masters, with write-burst locking and tagged read-data return.
module alt_ddr2_agx2_local_arbiter
    import alt_ddr2_agx2_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 256,
    parameter int BE_W      = 32,
    parameter int SIZE_W    = 3,
    parameter int TAG_DEPTH = 16
) (
    input  logic                          phy_clk,
    input  logic                          reset_phy_clk_n,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_address,
    input  logic [NUM_PORTS-1:0]          p_read_req,
    input  logic [NUM_PORTS-1:0]          p_write_req,
    input  logic [NUM_PORTS-1:0]          p_burstbegin,
    input  logic [NUM_PORTS*SIZE_W-1:0]   p_size,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata,
    input  logic [NUM_PORTS*BE_W-1:0]     p_be,
    output logic [NUM_PORTS-1:0]          p_ready,
    output logic [DATA_W-1:0]             p_rdata,
    output logic [NUM_PORTS-1:0]          p_rdata_valid,
    output logic [ADDR_W-1:0]             local_address,
    output logic [SIZE_W-1:0]             local_size,
    output logic [DATA_W-1:0]             local_wdata,
    output logic [BE_W-1:0]               local_be,
    output logic                          local_read_req,
    output logic                          local_write_req,
    output logic                          local_burstbegin,
    input  logic                          local_ready,
    input  logic [DATA_W-1:0]             local_rdata,
    input  logic                          local_rdata_valid,
    input  logic                          local_init_done,
    output logic                          rd_orphan_err
);

    arb_state_t               state_r, state_nxt_s;
    logic [TAG_PORT_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
    logic [TAG_PORT_W-1:0]    lock_port_r, lock_port_nxt_s;
    logic [TAG_SIZE_W-1:0]    beats_left_r, beats_left_nxt_s;
    logic [TAG_SIZE_W-1:0]    rbeat_r;
    logic                     orphan_r;

    logic                     en_s;
    logic [MAX_PORTS-1:0]     rd4_s, wr4_s, bb4_s, cand_s, ready4_s;
    logic [TAG_PORT_W:0]      pick_s;
    logic [TAG_PORT_W-1:0]    win_s;
    logic                     grant_s, rd_sel_s, wr_sel_s;
    logic                     acc_rd_s, acc_wr_s;
    logic [SIZE_W-1:0]        size_raw_s;
    logic [TAG_SIZE_W-1:0]    size_eff_s;

    logic                     fifo_full_s, fifo_empty_s, fifo_pop_s;
    tag_t                     head_s, push_tag_s;
    logic                     rv_s, hit_s;

    // Widen per-port strobes and pick the round-robin winner; reads are
    // excluded from arbitration while the tag FIFO cannot take another entry.
    always_comb begin
        en_s   = local_init_done & reset_phy_clk_n;
        rd4_s  = '0;
        wr4_s  = '0;
        bb4_s  = '0;
        rd4_s[NUM_PORTS-1:0] = p_read_req;
        wr4_s[NUM_PORTS-1:0] = p_write_req;
        bb4_s[NUM_PORTS-1:0] = p_burstbegin;
        if (fifo_full_s) begin
            cand_s = wr4_s;
        end else begin
            cand_s = rd4_s | wr4_s;
        end
        pick_s = rr_pick(cand_s, rr_ptr_r, NUM_PORTS);
    end

    // Grant selection and command mux onto the controller port.
    always_comb begin
        win_s    = pick_s[TAG_PORT_W-1:0];
        grant_s  = 1'b0;
        rd_sel_s = 1'b0;
        wr_sel_s = 1'b0;
        local_burstbegin = 1'b0;
        case (state_r)
            IDLE: begin
                grant_s  = en_s & pick_s[TAG_PORT_W];
                rd_sel_s = grant_s & rd4_s[win_s] & ~fifo_full_s;
                wr_sel_s = grant_s & ~rd_sel_s & wr4_s[win_s];
                local_burstbegin = grant_s & bb4_s[win_s];
            end
            WBURST: begin
                win_s    = lock_port_r;
                grant_s  = en_s;
                wr_sel_s = en_s & wr4_s[lock_port_r];
            end
            default: begin
                grant_s = 1'b0;
            end
        endcase
        size_raw_s    = p_size[int'(win_s)*SIZE_W +: SIZE_W];
        size_eff_s    = eff_size(TAG_SIZE_W'(size_raw_s));
        local_address = p_address[int'(win_s)*ADDR_W +: ADDR_W];
        local_size    = size_raw_s;
        local_wdata   = p_wdata[int'(win_s)*DATA_W +: DATA_W];
        local_be      = p_be[int'(win_s)*BE_W +: BE_W];
        local_read_req  = rd_sel_s;
        local_write_req = wr_sel_s;
        acc_rd_s = rd_sel_s & local_ready;
        acc_wr_s = wr_sel_s & local_ready;
        ready4_s = '0;
        if (grant_s) begin
            ready4_s[win_s] = local_ready;
        end else begin
            ready4_s = '0;
        end
        p_ready = ready4_s[NUM_PORTS-1:0];
    end

    // Next-state logic: round-robin pointer update and write-burst locking.
    always_comb begin
        state_nxt_s      = state_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        lock_port_nxt_s  = lock_port_r;
        beats_left_nxt_s = beats_left_r;
        case (state_r)
            IDLE: begin
                if (acc_rd_s) begin
                    rr_ptr_nxt_s = win_s;
                end else if (acc_wr_s) begin
                    if (size_eff_s <= TAG_SIZE_W'(1)) begin
                        rr_ptr_nxt_s = win_s;
                    end else begin
                        lock_port_nxt_s  = win_s;
                        beats_left_nxt_s = size_eff_s - TAG_SIZE_W'(1);
                        state_nxt_s      = WBURST;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WBURST: begin
                if (acc_wr_s) begin
                    if (beats_left_r <= TAG_SIZE_W'(1)) begin
                        beats_left_nxt_s = '0;
                        rr_ptr_nxt_s     = lock_port_r;
                        state_nxt_s      = IDLE;
                    end else begin
                        beats_left_nxt_s = beats_left_r - TAG_SIZE_W'(1);
                    end
                end else begin
                    state_nxt_s = WBURST;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Read return: steer each beat to the port at the head of the tag FIFO.
    always_comb begin
        rv_s       = en_s & local_rdata_valid;
        hit_s      = rv_s & ~fifo_empty_s;
        fifo_pop_s = hit_s & ((rbeat_r + TAG_SIZE_W'(1)) == head_s.size);
        push_tag_s = '{port: win_s, size: size_eff_s};
        p_rdata    = local_rdata;
        p_rdata_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            p_rdata_valid[i] = hit_s & (int'(head_s.port) == i);
        end
        rd_orphan_err = orphan_r;
    end

    // Arbitration state registers.
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            state_r      <= IDLE;
            rr_ptr_r     <= TAG_PORT_W'(NUM_PORTS - 1);
            lock_port_r  <= '0;
            beats_left_r <= '0;
        end else begin
            state_r      <= state_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            lock_port_r  <= lock_port_nxt_s;
            beats_left_r <= beats_left_nxt_s;
        end
    end

    // Read beat counter and sticky orphan-beat flag.
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            rbeat_r  <= '0;
            orphan_r <= 1'b0;
        end else begin
            if (fifo_pop_s) begin
                rbeat_r <= '0;
            end else if (hit_s) begin
                rbeat_r <= rbeat_r + TAG_SIZE_W'(1);
            end
            if (rv_s & fifo_empty_s) begin
                orphan_r <= 1'b1;
            end
        end
    end

    alt_ddr2_agx2_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (phy_clk),
        .rst_n    (reset_phy_clk_n),
        .push     (acc_rd_s),
        .push_tag (push_tag_s),
        .pop      (fifo_pop_s),
        .head     (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

endmodule

// File: tb/tb_alt_ddr2_agx2_local_arbiter.sv
// Directed + randomized bench for the DDR2 local-port arbiter, checked against
// a transaction-level model (grant search, burst lock, queue of pending reads).
module tb_alt_ddr2_agx2_local_arbiter;

    localparam int NP = 2;
    localparam int AW = 25;
    localparam int DW = 256;
    localparam int BW = 32;
    localparam int SW = 3;
    localparam int TD = 16;

    logic                 phy_clk;
    logic                 rst_n;
    logic [NP*AW-1:0]     p_address;
    logic [NP-1:0]        p_read_req, p_write_req, p_burstbegin;
    logic [NP*SW-1:0]     p_size;
    logic [NP*DW-1:0]     p_wdata;
    logic [NP*BW-1:0]     p_be;
    logic [NP-1:0]        p_ready;
    logic [DW-1:0]        p_rdata;
    logic [NP-1:0]        p_rdata_valid;
    logic [AW-1:0]        local_address;
    logic [SW-1:0]        local_size;
    logic [DW-1:0]        local_wdata;
    logic [BW-1:0]        local_be;
    logic                 local_read_req, local_write_req, local_burstbegin;
    logic                 local_ready;
    logic [DW-1:0]        local_rdata;
    logic                 local_rdata_valid;
    logic                 local_init_done;
    logic                 rd_orphan_err;

    alt_ddr2_agx2_local_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .SIZE_W(SW), .TAG_DEPTH(TD)
    ) dut (
        .phy_clk(phy_clk), .reset_phy_clk_n(rst_n),
        .p_address(p_address), .p_read_req(p_read_req), .p_write_req(p_write_req),
        .p_burstbegin(p_burstbegin), .p_size(p_size), .p_wdata(p_wdata), .p_be(p_be),
        .p_ready(p_ready), .p_rdata(p_rdata), .p_rdata_valid(p_rdata_valid),
        .local_address(local_address), .local_size(local_size), .local_wdata(local_wdata),
        .local_be(local_be), .local_read_req(local_read_req), .local_write_req(local_write_req),
        .local_burstbegin(local_burstbegin), .local_ready(local_ready),
        .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
        .local_init_done(local_init_done), .rd_orphan_err(rd_orphan_err)
    );

    initial phy_clk = 1'b0;
    always #5 phy_clk = ~phy_clk;

    // Reference model state.
    typedef struct { int port; int size; } rd_t;
    rd_t   m_q[$];
    int    m_rr, m_lock, m_left, m_rb;
    bit    m_burst, m_orphan;

    int    n_cmp = 0;
    int    n_err = 0;
    logic [NP-1:0] last_ready;
    logic          last_rd;

    task automatic mreset();
        m_q.delete();
        m_rr = NP - 1; m_lock = 0; m_left = 0; m_rb = 0;
        m_burst = 0; m_orphan = 0;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int j = 0; j < DW/32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_port(input int i, input bit rd, input bit wr, input bit bb, input int sz);
        p_read_req[i]   = rd;
        p_write_req[i]  = wr;
        p_burstbegin[i] = bb;
        p_size[i*SW +: SW]    = SW'(sz);
        p_address[i*AW +: AW] = AW'($urandom);
        p_wdata[i*DW +: DW]   = rand_data();
        p_be[i*BW +: BW]      = BW'($urandom);
    endtask

    task automatic idle_ports();
        for (int i = 0; i < NP; i++) drive_port(i, 0, 0, 0, 1);
    endtask

    // One clock: check combinational outputs against the model, then advance it.
    task automatic cycle();
        int w, idx, eff, sz;
        bit found, full, exp_rd, exp_wr, exp_bb;
        logic [NP-1:0] exp_ready, exp_rv;
        #1;
        if (!rst_n) mreset();
        exp_ready = '0; exp_rv = '0; exp_rd = 0; exp_wr = 0; exp_bb = 0;
        found = 0; w = 0;
        if (rst_n && local_init_done) begin
            if (m_burst) begin
                w = m_lock; found = 1;
                exp_wr = p_write_req[w];
                exp_ready[w] = local_ready;
            end else begin
                full = (m_q.size() == TD);
                for (int k = 1; k <= NP; k++) begin
                    idx = (m_rr + k) % NP;
                    if (!found && (full ? p_write_req[idx] : (p_read_req[idx] | p_write_req[idx]))) begin
                        found = 1; w = idx;
                    end
                end
                if (found) begin
                    exp_rd = !full && p_read_req[w];
                    exp_wr = !exp_rd && p_write_req[w];
                    exp_bb = p_burstbegin[w];
                    exp_ready[w] = local_ready;
                end
            end
            if (local_rdata_valid && m_q.size() > 0) exp_rv[m_q[0].port] = 1'b1;
        end
        sz  = int'(p_size[w*SW +: SW]);
        eff = (sz == 0) ? 1 : sz;
        chk("p_ready", p_ready, exp_ready);
        chk("local_read_req", local_read_req, exp_rd);
        chk("local_write_req", local_write_req, exp_wr);
        chk("local_burstbegin", local_burstbegin, exp_bb);
        chk("p_rdata_valid", p_rdata_valid, exp_rv);
        chk("rd_orphan_err", rd_orphan_err, m_orphan);
        chk("p_rdata", p_rdata, local_rdata);
        if (exp_rd || exp_wr) begin
            chk("local_address", local_address, p_address[w*AW +: AW]);
            chk("local_size", local_size, p_size[w*SW +: SW]);
        end
        if (exp_wr) begin
            chk("local_wdata", local_wdata, p_wdata[w*DW +: DW]);
            chk("local_be", local_be, p_be[w*BW +: BW]);
        end
        last_ready = p_ready;
        last_rd    = local_read_req;
        @(posedge phy_clk);
        if (rst_n) begin
            if (exp_rd && local_ready) begin
                m_q.push_back('{w, eff});
                m_rr = w;
            end
            if (exp_wr && local_ready) begin
                if (m_burst) begin
                    m_left--;
                    if (m_left == 0) begin m_burst = 0; m_rr = m_lock; end
                end else if (eff <= 1) begin
                    m_rr = w;
                end else begin
                    m_burst = 1; m_lock = w; m_left = eff - 1;
                end
            end
            if (local_init_done && local_rdata_valid) begin
                if (m_q.size() > 0) begin
                    m_rb++;
                    if (m_rb == m_q[0].size) begin void'(m_q.pop_front()); m_rb = 0; end
                end else begin
                    m_orphan = 1;
                end
            end
        end
        @(negedge phy_clk);
    endtask

    task automatic drain();
        idle_ports();
        local_ready = 1'b1;
        for (int g = 0; g < 200 && m_q.size() > 0; g++) begin
            local_rdata_valid = 1'b1;
            local_rdata = rand_data();
            cycle();
        end
        local_rdata_valid = 1'b0;
        chk("drain_empty", m_q.size() == 0, 1'b1);
    endtask

    initial begin
        mreset();
        rst_n = 1'b0; local_init_done = 1'b1; local_ready = 1'b1;
        local_rdata_valid = 1'b0; local_rdata = '0;
        p_read_req = '0; p_write_req = '0; p_burstbegin = '0;
        p_size = '0; p_address = '0; p_wdata = '0; p_be = '0;
        idle_ports();
        @(negedge phy_clk);

        // Reset held with requests present: everything quiet.
        drive_port(0, 1, 0, 1, 1); drive_port(1, 1, 0, 1, 1);
        local_rdata_valid = 1'b1;
        repeat (2) cycle();
        local_rdata_valid = 1'b0;
        rst_n = 1'b1;

        // Controller not initialised: no grants.
        local_init_done = 1'b0;
        repeat (2) cycle();
        local_init_done = 1'b1;

        // Both ports read every cycle: grants alternate starting at port 0.
        for (int k = 0; k < 6; k++) begin
            drive_port(0, 1, 0, 1, 1); drive_port(1, 1, 0, 1, 1);
            cycle();
            chk("alt_grant", last_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        drain();

        // Port 0 write burst of 4; port 1 read waits until the burst ends.
        for (int k = 0; k < 5; k++) begin
            drive_port(0, (k < 4) ? 0 : 0, (k < 4), 1, 4);
            drive_port(1, (k >= 1), 0, 1, 1);
            cycle();
            chk("burst_lock", last_ready, (k < 4) ? 2'b01 : 2'b10);
        end

        // Ready stalls mid-burst: no other grant, burst resumes afterwards.
        drive_port(0, 0, 1, 1, 4); drive_port(1, 1, 0, 1, 1);
        cycle();
        chk("stall_first_beat", last_ready, 2'b01);
        local_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_ready", last_ready, 2'b00);
            chk("stall_no_read", last_rd, 1'b0);
        end
        local_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_resume", last_ready, 2'b01);
        end
        drive_port(0, 0, 0, 0, 1);
        cycle();
        chk("stall_after", last_ready, 2'b10);
        drain();

        // Fill the tag FIFO with 16 reads, then the 17th is held off.
        for (int k = 0; k < TD; k++) begin
            drive_port(0, 1, 0, 1, 1);
            cycle();
            chk("fill_read", last_ready, 2'b01);
        end
        drive_port(1, 0, 1, 1, 1);
        cycle();
        chk("full_write_ok", last_ready, 2'b10);
        drive_port(1, 0, 0, 0, 1);
        cycle();
        chk("full_read_blocked", last_ready, 2'b00);
        drain();

        // Orphan beat: dropped, sticky error.
        local_rdata_valid = 1'b1; local_rdata = rand_data();
        cycle();
        local_rdata_valid = 1'b0;
        repeat (2) cycle();
        chk("orphan_sticky", rd_orphan_err, 1'b1);

        // Reset during a write burst with reads pending.
        for (int k = 0; k < 3; k++) begin
            drive_port(1, 1, 0, 1, 1);
            cycle();
        end
        drive_port(1, 0, 0, 0, 1);
        drive_port(0, 0, 1, 1, 4);
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        chk("reset_orphan", rd_orphan_err, 1'b0);
        rst_n = 1'b1;
        drive_port(0, 1, 0, 1, 1); drive_port(1, 1, 0, 1, 1);
        cycle();
        chk("post_reset_port0", last_ready, 2'b01);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NP; i++) begin
                drive_port(i, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                           $urandom_range(0, 1), $urandom_range(0, 7));
            end
            local_ready       = ($urandom_range(0, 3) != 0);
            local_init_done   = ($urandom_range(0, 19) != 0);
            local_rdata_valid = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                                 : ($urandom_range(0, 49) == 0);
            local_rdata       = rand_data();
            cycle();
        end
        local_init_done = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
